// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/operand/result bundle for the bit-serial
// subtractor. The master issues start/a/b and observes the result; the
// slave is the subtractor itself.
// Optional: SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b, LSB first, one full-subtractor
// stage and a registered borrow. Result is valid while done pulses and is held
// until the next accepted start.
// Optional: SERIAL_SUB_OVF_EN adds the registered signed-overflow flag ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_subtractor_if.slave     bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Full-subtractor difference bit
    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    // Full-subtractor borrow-out
    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   sa_r;
    logic [WIDTH-1:0]   sb_r;
    logic [WIDTH-1:0]   diff_r;
    logic               br_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               borrow_r;
    logic               busy_r;
    logic               done_r;
    logic               bit_d_s;
    logic               bit_br_s;
    logic               last_s;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_r;
    logic               b_msb_r;
    logic               ovf_r;
`endif

    assign bit_d_s  = fs_diff(sa_r[0], sb_r[0], br_r);
    assign bit_br_s = fs_borrow(sa_r[0], sb_r[0], br_r);
    assign last_s   = (cnt_r == CNT_W'(WIDTH - 1));

    // Next-state logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status flags registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
        end
    end

    // Operand load on accept, then one bit-step per cycle while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_r     <= '0;
            sb_r     <= '0;
            diff_r   <= '0;
            br_r     <= 1'b0;
            cnt_r    <= '0;
            borrow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        sa_r  <= bus.a;
                        sb_r  <= bus.b;
                        br_r  <= 1'b0;
                        cnt_r <= '0;
                    end else begin
                        sa_r  <= sa_r;
                        sb_r  <= sb_r;
                    end
                end
                ST_RUN: begin
                    diff_r <= {bit_d_s, diff_r[WIDTH-1:1]};
                    sa_r   <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r   <= {1'b0, sb_r[WIDTH-1:1]};
                    br_r   <= bit_br_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        borrow_r <= bit_br_s;
                    end else begin
                        borrow_r <= borrow_r;
                    end
                end
                default: begin
                    diff_r <= diff_r;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign capture and signed-overflow flag, set as the last bit lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && bus.start) begin
                a_msb_r <= bus.a[WIDTH-1];
                b_msb_r <= bus.b[WIDTH-1];
            end else if ((state_r == ST_RUN) && last_s) begin
                ovf_r <= (a_msb_r ^ b_msb_r) & (bit_d_s ^ a_msb_r);
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign bus.ovf = ovf_r;
`endif

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.diff   = diff_r;
    assign bus.borrow = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at
// WIDTH=8 and WIDTH=2 against an arithmetic reference model.
// Optional: SERIAL_SUB_OVF_EN enables ovf checks.
module tb_serial_subtractor;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(2)) bus2 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full WIDTH=8 operation with latency, pulse-width and result checks
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] exp_diff;
        logic       exp_borrow;
        int         sres;
        exp_diff   = a - b;
        exp_borrow = (a < b);
        sres       = int'($signed(a)) - int'($signed(b));
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        step();                              // accepting edge k
        bus8.start = 1'b0;
        bus8.a     = ~a;                     // operands may change after accept
        bus8.b     = ~b;
        check({tag, ".busy_k"}, 32'(bus8.busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i < 8) begin
                if (bus8.done !== 1'b0) check({tag, ".early_done"}, 32'(bus8.done), 32'd0);
            end else begin
                check({tag, ".done"}, 32'(bus8.done), 32'd1);
                check({tag, ".diff"}, 32'(bus8.diff), 32'(exp_diff));
                check({tag, ".borrow"}, 32'(bus8.borrow), 32'(exp_borrow));
`ifdef SERIAL_SUB_OVF_EN
                check({tag, ".ovf"}, 32'(bus8.ovf), 32'((sres > 127) || (sres < -128)));
`endif
            end
        end
        step();
        check({tag, ".done_fall"}, 32'({bus8.done, bus8.busy}), 32'd0);
        check({tag, ".diff_hold"}, 32'(bus8.diff), 32'(exp_diff));
        if (sres == 1000) check({tag, ".unused"}, 32'd0, 32'd0);
    endtask

    initial begin
        int         done_cnt;
        int         done_pos [2];
        logic [7:0] done_diff;
        logic       done_borrow;
        n_cmp      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = 8'h00;
        bus8.b     = 8'h00;
        bus2.start = 1'b0;
        bus2.a     = 2'b00;
        bus2.b     = 2'b00;
        step();
        step();
        check("reset.outs8", 32'({bus8.busy, bus8.done, bus8.borrow, bus8.diff}), 32'd0);
        check("reset.outs2", 32'({bus2.busy, bus2.done, bus2.borrow, bus2.diff}), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset.ovf", 32'(bus8.ovf), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        run8(8'd20, 8'd7, "basic");
        run8(8'd7, 8'd20, "neg");
        run8(8'h00, 8'hFF, "zero_minus_ff");
        run8(8'h80, 8'h01, "ovf_pos");
        run8(8'h05, 8'h03, "ovf_none");
        run8(8'hFF, 8'hFF, "equal");

        // Start held high for 20 cycles: one op per 10 cycles, no early restart
        bus8.a     = 8'hAA;
        bus8.b     = 8'hAA;
        bus8.start = 1'b1;
        done_cnt   = 0;
        done_pos   = '{0, 0};
        done_diff  = 8'h55;
        done_borrow = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (bus8.done === 1'b1) begin
                if (done_cnt < 2) done_pos[done_cnt] = e;
                if (done_cnt == 0) begin
                    done_diff   = bus8.diff;
                    done_borrow = bus8.borrow;
                end
                done_cnt++;
            end
            if (e == 10) check("held.idle_gap", 32'(bus8.busy), 32'd0);
        end
        bus8.start = 1'b0;
        check("held.done_cnt", 32'(done_cnt), 32'd2);
        check("held.done_pos0", 32'(done_pos[0]), 32'd9);
        check("held.done_pos1", 32'(done_pos[1]), 32'd19);
        check("held.diff", 32'({done_borrow, done_diff}), 32'd0);
        step();
        step();
        check("held.idle_after", 32'(bus8.busy), 32'd0);

        // Reset during the 4th RUN cycle aborts with no done pulse
        bus8.a     = 8'd50;
        bus8.b     = 8'd9;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid.outs", 32'({bus8.busy, bus8.done, bus8.borrow, bus8.diff}), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_mid.ovf", 32'(bus8.ovf), 32'd0);
`endif
        step();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (bus8.done === 1'b1) done_cnt++;
        end
        check("rst_mid.no_done", 32'(done_cnt), 32'd0);
        run8(8'd100, 8'd1, "after_rst");

        // Minimum width instance
        bus2.a     = 2'b01;
        bus2.b     = 2'b10;
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        check("w2.busy_k", 32'(bus2.busy), 32'd1);
        step();
        check("w2.no_done_k1", 32'(bus2.done), 32'd0);
        step();
        check("w2.done", 32'(bus2.done), 32'd1);
        check("w2.diff", 32'(bus2.diff), 32'd3);
        check("w2.borrow", 32'(bus2.borrow), 32'd1);
        step();
        check("w2.done_fall", 32'({bus2.done, bus2.busy}), 32'd0);

        // Random operands against the arithmetic model
        for (int i = 0; i < 25; i++) begin
            run8(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
